// File: rtl/alu_16bit_sequencer_pkg.sv
// Shared encodings for the 16-bit arithmetic sequencer: ops, FSM states, flag bit positions.
// The optional single-pass build is selected with ALU16_SINGLE_PASS_EN.
package alu_16bit_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_INC   = 2'b00,
      OP_DEC   = 2'b01,
      OP_ADD16 = 2'b10,
      OP_ADDSP = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOW  = 2'b01,
      ST_HIGH = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_H = 1;
   localparam int FLAG_C = 0;

   // DEC is an add of all-ones; ADDSP sign-extends the 8-bit displacement.
   function automatic logic [15:0] b_effective(input op_e op, input logic [15:0] b);
      logic [15:0] r;
      r = 16'h0001;
      case (op)
         OP_INC:   r = 16'h0001;
         OP_DEC:   r = 16'hFFFF;
         OP_ADD16: r = b;
         OP_ADDSP: r = {{8{b[7]}}, b[7:0]};
         default:  r = 16'h0001;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_16bit_sequencer_if.sv
// Request/response bundle between the decoder (master) and the 16-bit sequencer (slave).
// Shared by the default build and the ALU16_SINGLE_PASS_EN build.
interface alu_16bit_sequencer_if;
   logic        i_Enable;
   logic        i_Start;
   logic [1:0]  i_Op;
   logic [15:0] i_Operand_A;
   logic [15:0] i_Operand_B;
   logic [3:0]  i_F;
   logic        o_Busy;
   logic        o_Done;
   logic [15:0] o_Result;
   logic [3:0]  o_Ext_Flags;
   logic        o_Save_Flags;

   modport master (
      output i_Enable, i_Start, i_Op, i_Operand_A, i_Operand_B, i_F,
      input  o_Busy, o_Done, o_Result, o_Ext_Flags, o_Save_Flags
   );

   modport slave (
      input  i_Enable, i_Start, i_Op, i_Operand_A, i_Operand_B, i_F,
      output o_Busy, o_Done, o_Result, o_Ext_Flags, o_Save_Flags
   );
endinterface

// File: rtl/alu_16bit_sequencer_byte_adder.sv
// 8-bit a+b+cin with half-carry (out of bit 3) and carry (out of bit 7).
// Used once normally, twice chained under ALU16_SINGLE_PASS_EN.
module byte_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       half_carry,
   output logic       carry
);
   logic [4:0] nibble;
   logic [8:0] full;

   assign nibble     = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
   assign full       = {1'b0, a} + {1'b0, b} + {8'h00, cin};
   assign sum        = full[7:0];
   assign half_carry = nibble[4];
   assign carry      = full[8];
endmodule

// File: rtl/alu_16bit_sequencer.sv
// Multi-cycle 16-bit INC/DEC/ADD16/ADDSP built on a shared byte adder (low pass, then high pass).
// Define ALU16_SINGLE_PASS_EN to chain two byte adders and drop the HIGH state.
module alu_16bit_sequencer
   import alu_16bit_sequencer_pkg::*;
(
   input  logic                   i_Clk,
   input  logic                   i_Reset_n,
   alu_16bit_sequencer_if.slave   bus
);

   state_e      state_q, state_d;
   logic [15:0] a_p0, b_p0;
   op_e         op_p0;
   logic        z_p0;
   logic [7:0]  sum_lo_p1;
   logic        c7_p1, h3_p1;
   logic        c15_p2, h11_p2;
   logic [15:0] result_p2;
   logic [7:0]  lo_sum, hi_sum;
   logic        lo_h, lo_c, hi_h, hi_c;

`ifdef ALU16_SINGLE_PASS_EN
   byte_adder u_add_lo (.a(a_p0[7:0]),  .b(b_p0[7:0]),  .cin(1'b0), .sum(lo_sum), .half_carry(lo_h), .carry(lo_c));
   byte_adder u_add_hi (.a(a_p0[15:8]), .b(b_p0[15:8]), .cin(lo_c), .sum(hi_sum), .half_carry(hi_h), .carry(hi_c));
`else
   logic [7:0] add_a, add_b;
   logic       add_cin;

   // The single adder sees the low bytes in LOW and the high bytes plus c7 in HIGH.
   always_comb begin
      add_a   = (state_q == ST_HIGH) ? a_p0[15:8] : a_p0[7:0];
      add_b   = (state_q == ST_HIGH) ? b_p0[15:8] : b_p0[7:0];
      add_cin = (state_q == ST_HIGH) ? c7_p1 : 1'b0;
   end

   byte_adder u_add (.a(add_a), .b(add_b), .cin(add_cin), .sum(lo_sum), .half_carry(lo_h), .carry(lo_c));
   assign hi_sum = lo_sum;
   assign hi_h   = lo_h;
   assign hi_c   = lo_c;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.i_Start) state_d = ST_LOW;
`ifdef ALU16_SINGLE_PASS_EN
         ST_LOW:  state_d = ST_DONE;
`else
         ST_LOW:  state_d = ST_HIGH;
`endif
         ST_HIGH: state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         state_q   <= ST_IDLE;
         result_p2 <= '0;
      end else if (bus.i_Enable) begin
         state_q <= state_d;
         case (state_q)
            // p0: operand capture
            ST_IDLE: if (bus.i_Start) begin
               a_p0  <= bus.i_Operand_A;
               b_p0  <= b_effective(op_e'(bus.i_Op), bus.i_Operand_B);
               op_p0 <= op_e'(bus.i_Op);
               z_p0  <= bus.i_F[FLAG_Z];
            end
            // p1: low byte (and, single-pass, the high byte too)
            ST_LOW: begin
               sum_lo_p1 <= lo_sum;
               c7_p1     <= lo_c;
               h3_p1     <= lo_h;
`ifdef ALU16_SINGLE_PASS_EN
               c15_p2    <= hi_c;
               h11_p2    <= hi_h;
               result_p2 <= {hi_sum, lo_sum};
`endif
            end
            // p2: high byte, result assembled on entry to DONE
            ST_HIGH: begin
               c15_p2    <= hi_c;
               h11_p2    <= hi_h;
               result_p2 <= {hi_sum, sum_lo_p1};
            end
            default: ;
         endcase
      end
   end

   // Downstream ALU ORs these flags into its bus, so they stay zero outside DONE.
   always_comb begin
      bus.o_Ext_Flags  = 4'b0000;
      bus.o_Save_Flags = 1'b0;
      if (state_q == ST_DONE) begin
         case (op_p0)
            OP_ADD16: begin
               bus.o_Ext_Flags[FLAG_Z] = z_p0;
               bus.o_Ext_Flags[FLAG_N] = 1'b0;
               bus.o_Ext_Flags[FLAG_H] = h11_p2;
               bus.o_Ext_Flags[FLAG_C] = c15_p2;
               bus.o_Save_Flags        = 1'b1;
            end
            OP_ADDSP: begin
               bus.o_Ext_Flags[FLAG_H] = h3_p1;
               bus.o_Ext_Flags[FLAG_C] = c7_p1;
               bus.o_Save_Flags        = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_Busy   = (state_q != ST_IDLE);
   assign bus.o_Done   = (state_q == ST_DONE);
   assign bus.o_Result = result_p2;

endmodule

// File: tb/tb_alu_16bit_sequencer.sv
// Directed, table-driven bench for alu_16bit_sequencer plus hand sequences for
// start-while-busy, enable stalls and reset mid-operation.
`timescale 1ns/1ps
module tb_alu_16bit_sequencer;
   import alu_16bit_sequencer_pkg::*;

`ifdef ALU16_SINGLE_PASS_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_16bit_sequencer_if bus ();

   alu_16bit_sequencer dut (
      .i_Clk     (clk),
      .i_Reset_n (rst_n),
      .bus       (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  f;
      logic [15:0] res;
      logic [3:0]  flags;
      logic        save;
   } vec_t;

   vec_t vecs [10];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic [15:0] exp_res);
      check({tag, " busy"},  16'(bus.o_Busy), 16'd0);
      check({tag, " done"},  16'(bus.o_Done), 16'd0);
      check({tag, " flags"}, 16'(bus.o_Ext_Flags), 16'd0);
      check({tag, " save"},  16'(bus.o_Save_Flags), 16'd0);
      check({tag, " result"}, bus.o_Result, exp_res);
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int k;
      bus.i_Op        = v.op;
      bus.i_Operand_A = v.a;
      bus.i_Operand_B = v.b;
      bus.i_F         = v.f;
      bus.i_Start     = 1'b1;
      tick();
      // scramble inputs so only latched values can produce the answer
      bus.i_Start     = 1'b0;
      bus.i_Operand_A = ~v.a;
      bus.i_Operand_B = ~v.b;
      bus.i_F         = ~v.f;
      k = 1;
      while (k < 12 && !bus.o_Done) begin
         check({tag, " busy"},  16'(bus.o_Busy), 16'd1);
         check({tag, " early flags"}, 16'(bus.o_Ext_Flags), 16'd0);
         check({tag, " early save"},  16'(bus.o_Save_Flags), 16'd0);
         tick();
         k++;
      end
      check({tag, " latency"}, 16'(k), 16'(LAT));
      check({tag, " done"},   16'(bus.o_Done), 16'd1);
      check({tag, " result"}, bus.o_Result, v.res);
      check({tag, " flags"},  16'(bus.o_Ext_Flags), 16'(v.flags));
      check({tag, " save"},   16'(bus.o_Save_Flags), 16'(v.save));
      tick();
      check_idle({tag, " after"}, v.res);
   endtask

   initial begin
      int pulses;
      vec_t v;

      vecs[0] = '{2'b10, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b1};
      vecs[1] = '{2'b10, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 1'b1};
      vecs[2] = '{2'b11, 16'hFFF8, 16'h0008, 4'b0000, 16'h0000, 4'b0011, 1'b1};
      vecs[3] = '{2'b11, 16'h0005, 16'h00FE, 4'b1000, 16'h0003, 4'b0011, 1'b1};
      vecs[4] = '{2'b00, 16'hFFFF, 16'hABCD, 4'b1111, 16'h0000, 4'b0000, 1'b0};
      vecs[5] = '{2'b01, 16'h0000, 16'h1234, 4'b1111, 16'hFFFF, 4'b0000, 1'b0};
      vecs[6] = '{2'b10, 16'h1234, 16'h4321, 4'b1000, 16'h5555, 4'b1000, 1'b1};
      vecs[7] = '{2'b11, 16'h1000, 16'h1280, 4'b0000, 16'h0F80, 4'b0000, 1'b1};
      vecs[8] = '{2'b10, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b0001, 1'b1};
      vecs[9] = '{2'b00, 16'h00FF, 16'h0000, 4'b0000, 16'h0100, 4'b0000, 1'b0};

      bus.i_Enable    = 1'b1;
      bus.i_Start     = 1'b0;
      bus.i_Op        = 2'b00;
      bus.i_Operand_A = 16'h0000;
      bus.i_Operand_B = 16'h0000;
      bus.i_F         = 4'b0000;
      rst_n           = 1'b0;
      tick();
      tick();
      check_idle("reset", 16'h0000);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // start held through LOW/HIGH/DONE: exactly one operation, no restart from DONE
      bus.i_Op = 2'b10; bus.i_Operand_A = 16'h0FFF; bus.i_Operand_B = 16'h0001; bus.i_F = 4'b1000;
      bus.i_Start = 1'b1;
      tick();
      bus.i_Operand_A = 16'h1111; bus.i_Operand_B = 16'h2222;
      pulses = 0;
      for (int i = 1; i < LAT; i++) begin
         if (bus.o_Done) pulses++;
         tick();
      end
      check("hold done", 16'(bus.o_Done), 16'd1);
      check("hold result", bus.o_Result, 16'h1000);
      check("hold flags", 16'(bus.o_Ext_Flags), 16'hA);
      if (bus.o_Done) pulses++;
      tick();
      check("start in DONE ignored", 16'(bus.o_Busy), 16'd0);
      bus.i_Start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (bus.o_Done) pulses++;
         tick();
      end
      check("hold pulses", 16'(pulses), 16'd1);
      check("hold idle", 16'(bus.o_Busy), 16'd0);

      // enable low for 3 cycles mid-operation, then low again while in DONE
      bus.i_Op = 2'b10; bus.i_Operand_A = 16'hFFFF; bus.i_Operand_B = 16'h0001; bus.i_F = 4'b0000;
      bus.i_Start = 1'b1;
      tick();
      bus.i_Start = 1'b0;
      for (int i = 0; i < LAT - 2; i++) tick();
      bus.i_Enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall done", 16'(bus.o_Done), 16'd0);
         check("stall busy", 16'(bus.o_Busy), 16'd1);
      end
      bus.i_Enable = 1'b1;
      tick();
      check("stall late done", 16'(bus.o_Done), 16'd1);
      check("stall result", bus.o_Result, 16'h0000);
      bus.i_Enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("frozen done", 16'(bus.o_Done), 16'd1);
         check("frozen flags", 16'(bus.o_Ext_Flags), 16'h3);
         check("frozen save", 16'(bus.o_Save_Flags), 16'd1);
      end
      bus.i_Enable = 1'b1;
      tick();
      check_idle("unfrozen", 16'h0000);

      // reset in the last compute state aborts with no done or flag write
      bus.i_Op = 2'b10; bus.i_Operand_A = 16'h1234; bus.i_Operand_B = 16'h0001; bus.i_F = 4'b1000;
      bus.i_Start = 1'b1;
      tick();
      bus.i_Start = 1'b0;
      for (int i = 0; i < LAT - 2; i++) tick();
      rst_n = 1'b0;
      tick();
      check_idle("abort", 16'h0000);
      rst_n = 1'b1;
      tick();
      check_idle("abort next", 16'h0000);
      v = vecs[0];
      run_op(v, "post-abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
